// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Data-side bus between the CPU and the multi-cycle data memory responder.
//
// Signals:
//   MemRead_i   CPU -> mem  read request, held while stall_o is high
//   MemWrite_i  CPU -> mem  write request, held while stall_o is high
//   addr_i      CPU -> mem  32-bit byte address
//   data_i      CPU -> mem  32-bit write data
//   data_o      mem -> CPU  32-bit read data, valid with done_o on a read
//   stall_o     mem -> CPU  holds the CPU while an access is in flight
//   done_o      mem -> CPU  one-cycle completion pulse
//   err_o       mem -> CPU  one-cycle pulse with done_o when access rejected
//
// Modports:
//   master  CPU side (drives requests)
//   slave   memory side (drives responses)
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output MemRead_i,
        output MemWrite_i,
        output addr_i,
        output data_i,
        input  data_o,
        input  stall_o,
        input  done_o,
        input  err_o
    );

    modport slave (
        input  MemRead_i,
        input  MemWrite_i,
        input  addr_i,
        input  data_i,
        output data_o,
        output stall_o,
        output done_o,
        output err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Configurable-latency 32-bit word store on the CPU data port. Each access
// goes IDLE -> WAIT (LATENCY cycles) -> RESP. The CPU is held with stall_o
// until RESP, where done_o pulses (with err_o for rejected accesses).
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (byte range 0 .. 4*DEPTH_WORDS-1)
//   LATENCY      WAIT-state cycles per access, legal range 1..15
//
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset; also clears the whole memory
//   bus    data_mem_responder_if.slave (requests in, responses out)
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_mem_responder_if.slave   bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;

    logic              req;
    logic              req_err;
    logic              is_write_q;
    logic              err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              finish_access;

    logic [31:0] mem [DEPTH_WORDS];

    assign req = bus.MemRead_i | bus.MemWrite_i;

    // Rejected accesses: misaligned, beyond the store, or read and write
    // requested together. Evaluated only when a request is accepted.
    assign req_err = (bus.addr_i[1:0] != 2'b00)
                   | ({1'b0, bus.addr_i} >= ADDR_LIMIT)
                   | (bus.MemRead_i & bus.MemWrite_i);

    // The memory side effect happens on the WAIT -> RESP edge.
    assign finish_access = (state == WAIT) && (cnt == 4'd0);

    // State and wait counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic. Inputs are only looked at in IDLE; a request that
    // drops mid-WAIT still runs to completion.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n = WAIT;
                    cnt_n   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Capture the request when it is accepted so later input changes
    // cannot affect the access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
        end else if (state == IDLE && req) begin
            is_write_q <= bus.MemWrite_i;
            err_q      <= req_err;
            idx_q      <= bus.addr_i[ADDR_W+1:2];
            wdata_q    <= bus.data_i;
        end
    end

    // Word store and read-data register. Reset wipes every word, which is
    // also how a reset during WAIT aborts a pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
            rdata_q <= 32'd0;
        end else if (finish_access) begin
            if (err_q) begin
                rdata_q <= 32'd0;
            end else if (is_write_q) begin
                mem[idx_q] <= wdata_q;
            end else begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // stall_o follows the live request so it drops early if the CPU lets go.
    assign bus.stall_o = req & (state != RESP);
    assign bus.done_o  = (state == RESP);
    assign bus.err_o   = (state == RESP) & err_q;
    assign bus.data_o  = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed scoreboard bench for data_mem_responder (DEPTH_WORDS=128,
// LATENCY=2). Stimulus pushes the hand-computed response into a queue; a
// monitor pops and compares whenever done_o is seen.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH   = 128;
    localparam int LAT     = 2;

    logic clk;
    logic rst;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparison: every check in the bench comes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issue one access, push its expected response, and measure stall/done
    // timing. Returns right after done_o is seen (in the RESP cycle) so a
    // following call can issue a back-to-back request.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic exp_err, input logic [31:0] exp_data,
                                 output int cycles);
        exp_t e;
        int   stalls;
        bit   got;
        e.err  = exp_err;
        e.data = exp_data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        bus.addr_i     = addr;
        bus.data_i     = wdata;
        cycles = 0;
        stalls = 0;
        got    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.stall_o) stalls++;
            if (bus.done_o) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({name, "_done_seen"}, 32'(got), 32'd1);
        checkOutput({name, "_stall_cycles"}, 32'(stalls), 32'(LAT + 1));
        checkOutput({name, "_done_cycle"}, 32'(cycles), 32'(LAT + 2));
    endtask

    task automatic goIdle(input int n);
        @(posedge clk);
        #1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        bus.addr_i     = 32'd0;
        bus.data_i     = 32'd0;
        repeat (n) @(posedge clk);
    endtask

    // Monitor: compare each completion against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("resp_err", 32'(bus.err_o), 32'(e.err));
                    checkOutput("resp_data", bus.data_o, e.data);
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int c1;
        int c2;
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        bus.addr_i     = 32'd0;
        bus.data_i     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", 32'(bus.stall_o), 32'd0);
        checkOutput("rst_done", 32'(bus.done_o), 32'd0);
        checkOutput("rst_err", 32'(bus.err_o), 32'd0);
        checkOutput("rst_data", bus.data_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: write 0x10; data_o keeps its reset value
        applyStimulus("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, c1);
        goIdle(2);

        // 2: read 0x10, then data_o holds after the request drops
        applyStimulus("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, c1);
        goIdle(3);
        @(negedge clk);
        checkOutput("data_hold", bus.data_o, 32'hDEADBEEF);

        // 3: misaligned write rejected, read-back unchanged
        applyStimulus("wr12_mis", 1'b0, 1'b1, 32'h12, 32'h12345678, 1'b1, 32'h0, c1);
        goIdle(1);
        applyStimulus("rd10_b", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, c1);
        goIdle(1);

        // 4: out-of-range read, simultaneous read+write, memory untouched
        applyStimulus("rd200_oor", 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0, c1);
        goIdle(1);
        applyStimulus("rdwr0", 1'b1, 1'b1, 32'h0, 32'h55555555, 1'b1, 32'h0, c1);
        goIdle(1);
        applyStimulus("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, c1);
        goIdle(1);
        applyStimulus("rd10_c", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, c1);
        goIdle(1);
        applyStimulus("rd1fc", 1'b1, 1'b0, 32'h1FC, 32'h0, 1'b0, 32'h0, c1);
        goIdle(1);

        // 5: back-to-back write then read of 0x8
        applyStimulus("wr8", 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0, 32'h0, c1);
        applyStimulus("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5A5A5, c2);
        checkOutput("b2b_total_cycles", 32'(c1 + c2), 32'd8);
        goIdle(2);

        // 6: reset during the second WAIT cycle of a write aborts it
        @(posedge clk);
        #1;
        bus.MemWrite_i = 1'b1;
        bus.addr_i     = 32'h4;
        bus.data_i     = 32'h11111111;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        bus.MemWrite_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_stall", 32'(bus.stall_o), 32'd0);
        checkOutput("abort_done", 32'(bus.done_o), 32'd0);
        checkOutput("abort_data", bus.data_o, 32'd0);
        repeat (4) @(posedge clk);
        applyStimulus("rd4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, c1);
        goIdle(1);
        applyStimulus("rd10_clr", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, c1);
        goIdle(4);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
